pwm_multi: RTL and testbench

//   N-channel PWM generator sharing one prescaler and one period counter.
//   Per-channel duty cycles go through a clamped shadow register and load glitch-free at the period boundary.

---
 rtl/pwm_pkg.sv | 30 +++
 rtl/pwm_channel.sv | 52 +++++
 rtl/pwm_multi.sv | 155 +++++++++++++++
 tb/tb_pwm_multi.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and helpers for the multi-channel PWM.
//   duty_t    : duty value at the default 8-bit resolution. Modules are
//               parameterized by RES_W and declare their own widths from it.
//   cnt_dir_e : period counter direction. Used only in the center-aligned
//               build (PWM_MULTI_CENTER_EN).
//   clamp()   : saturates a value into [lo, hi].
package pwm_pkg;

    localparam int DUTY_W = 8;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } cnt_dir_e;

    function automatic logic [31:0] clamp(input logic [31:0] v,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
        if (v < lo) begin
            return lo;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output with a shadow/active duty pair.
//   clk      in  clock
//   rst_n    in  asynchronous reset, active low
//   wr_en    in  load wr_duty into the shadow register
//   wr_duty  in  already-clamped duty value
//   load     in  period boundary: copy shadow into active
//   oe       in  output enable
//   cnt      in  shared period counter value
//   out      out registered compare result
module pwm_channel #(
    parameter int RES_W      = 8,
    parameter int RESET_DUTY = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [RES_W-1:0] wr_duty,
    input  logic             load,
    input  logic             oe,
    input  logic [RES_W-1:0] cnt,
    output logic             out
);
    import pwm_pkg::*;

    logic [RES_W-1:0] shadow_reg;
    logic [RES_W-1:0] active_reg;
    logic             out_reg;

    // The active value changes only together with the counter wrap. The
    // compare therefore always sees a consistent (cnt, active) pair, and no
    // glitch can occur at the boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg <= RES_W'(RESET_DUTY);
            active_reg <= RES_W'(RESET_DUTY);
            out_reg    <= 1'b0;
        end else begin
            // active samples the shadow value from before any write in this
            // same cycle. A write at the boundary waits one more period.
            if (load) begin
                active_reg <= shadow_reg;
            end
            if (wr_en) begin
                shadow_reg <= wr_duty;
            end
            out_reg <= oe & (cnt < active_reg);
        end
    end

    assign out = out_reg;

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: N-channel PWM with a shared prescaler and period counter.
//   clk          in  system clock
//   rst_n        in  asynchronous reset, active low
//   run          in  1: counters advance, 0: counters hold
//   oe           in  per-channel output enable
//   duty_valid   in  duty write strobe
//   duty_ch      in  target channel (>= N_CH ignored)
//   duty         in  requested duty in ticks
//   out          out PWM outputs
//   out_en       out registered oe
//   period_tick  out one-cycle pulse after each period boundary
//   clamped      out one-cycle pulse when the last accepted write was clamped
// Build option: define PWM_MULTI_CENTER_EN for center-aligned (up/down)
// counting. The default build is edge-aligned.
module pwm_multi #(
    parameter int N_CH       = 4,
    parameter int RES_W      = 8,
    parameter int PERIOD     = 100,
    parameter int PRESC      = 2,
    parameter int DUTY_MIN   = 0,
    parameter int DUTY_MAX   = PERIOD,
    parameter int RESET_DUTY = PERIOD / 2,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [N_CH-1:0]  oe,
    input  logic             duty_valid,
    input  logic [CH_W-1:0]  duty_ch,
    input  logic [RES_W-1:0] duty,
    output logic [N_CH-1:0]  out,
    output logic [N_CH-1:0]  out_en,
    output logic             period_tick,
    output logic             clamped
);
    import pwm_pkg::*;

    localparam int DIV_W = (PRESC > 1) ? $clog2(PRESC) : 1;

    if (PRESC < 1) begin : g_bad_presc
        $error("pwm_multi: PRESC must be >= 1");
    end
    if (PERIOD >= (2 ** RES_W) || PERIOD < 2) begin : g_bad_period
        $error("pwm_multi: PERIOD must be in 2..2**RES_W-1");
    end
    if (DUTY_MIN > DUTY_MAX || DUTY_MAX > PERIOD) begin : g_bad_clamp
        $error("pwm_multi: need DUTY_MIN <= DUTY_MAX <= PERIOD");
    end

    logic [DIV_W-1:0] div_reg, div_next;
    logic [RES_W-1:0] cnt_reg, cnt_next;
    logic             tick;
    logic             boundary;
    logic             period_tick_reg;
    logic             clamped_reg;
    logic [N_CH-1:0]  out_en_reg;
`ifdef PWM_MULTI_CENTER_EN
    cnt_dir_e         dir_reg, dir_next;
`endif

    assign tick = run & (div_reg == DIV_W'(PRESC - 1));

    always_comb begin
        div_next = div_reg;
        cnt_next = cnt_reg;
        boundary = 1'b0;
`ifdef PWM_MULTI_CENTER_EN
        dir_next = dir_reg;
`endif
        if (run) begin
            div_next = tick ? '0 : div_reg + 1'b1;
        end
        if (tick) begin
`ifdef PWM_MULTI_CENTER_EN
            // The counter holds for one tick at each end while the direction
            // flips. That makes a full cycle 2*PERIOD ticks, symmetric around
            // cnt=0. The bottom turn-around is the boundary.
            if (dir_reg == DIR_UP) begin
                if (cnt_reg == RES_W'(PERIOD - 1)) begin
                    dir_next = DIR_DOWN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end else begin
                if (cnt_reg == '0) begin
                    dir_next = DIR_UP;
                    boundary = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
`else
            if (cnt_reg == RES_W'(PERIOD - 1)) begin
                cnt_next = '0;
                boundary = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
`endif
        end
    end

    // Write decode: clamp once here so that every channel stores a legal value.
    logic             ch_ok;
    logic [RES_W-1:0] duty_clamped;
    logic             write_ok;

    assign ch_ok        = 32'(duty_ch) < 32'(N_CH);
    assign write_ok     = duty_valid & ch_ok;
    assign duty_clamped = RES_W'(clamp(32'(duty), 32'(DUTY_MIN), 32'(DUTY_MAX)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg         <= '0;
            cnt_reg         <= '0;
            period_tick_reg <= 1'b0;
            clamped_reg     <= 1'b0;
            out_en_reg      <= '0;
`ifdef PWM_MULTI_CENTER_EN
            dir_reg         <= DIR_UP;
`endif
        end else begin
            div_reg         <= div_next;
            cnt_reg         <= cnt_next;
            period_tick_reg <= boundary;
            clamped_reg     <= write_ok & (duty_clamped != duty);
            out_en_reg      <= oe;
`ifdef PWM_MULTI_CENTER_EN
            dir_reg         <= dir_next;
`endif
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        pwm_channel #(
            .RES_W      (RES_W),
            .RESET_DUTY (RESET_DUTY)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (write_ok & (duty_ch == CH_W'(gi))),
            .wr_duty (duty_clamped),
            .load    (boundary),
            .oe      (oe[gi]),
            .cnt     (cnt_reg),
            .out     (out[gi])
        );
    end

    assign out_en      = out_en_reg;
    assign period_tick = period_tick_reg;
    assign clamped     = clamped_reg;

endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;

    localparam int N_CH   = 4;
    localparam int RES_W  = 8;
    localparam int PERIOD = 10;
    localparam int PRESC  = 2;
`ifdef PWM_MULTI_CENTER_EN
    localparam int EXP_PER_CLK  = 2 * PERIOD * PRESC;
    localparam int EXP_HIGH_CLK = 2 * (PERIOD / 2) * PRESC;
`else
    localparam int EXP_PER_CLK  = PERIOD * PRESC;
    localparam int EXP_HIGH_CLK = (PERIOD / 2) * PRESC;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic [N_CH-1:0]  oe = '0;
    logic             duty_valid = 1'b0;
    logic [1:0]       duty_ch = '0;
    logic [RES_W-1:0] duty = '0;

    logic [N_CH-1:0]  out_a, out_en_a, out_b, out_en_b;
    logic             ptick_a, ptick_b, clamped_a, clamped_b;

    always #5 clk = ~clk;

    // Instance A: full range 0..PERIOD. Instance B: clamp range 1..9.
    pwm_multi #(.N_CH(N_CH), .RES_W(RES_W), .PERIOD(PERIOD), .PRESC(PRESC),
                .DUTY_MIN(0), .DUTY_MAX(PERIOD), .RESET_DUTY(PERIOD / 2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .run(run), .oe(oe), .duty_valid(duty_valid),
        .duty_ch(duty_ch), .duty(duty), .out(out_a), .out_en(out_en_a),
        .period_tick(ptick_a), .clamped(clamped_a));

    pwm_multi #(.N_CH(N_CH), .RES_W(RES_W), .PERIOD(PERIOD), .PRESC(PRESC),
                .DUTY_MIN(1), .DUTY_MAX(9), .RESET_DUTY(PERIOD / 2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .run(run), .oe(oe), .duty_valid(duty_valid),
        .duty_ch(duty_ch), .duty(duty), .out(out_b), .out_en(out_en_b),
        .period_tick(ptick_b), .clamped(clamped_b));

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. It counts elapsed run cycles and elapsed ticks, and
    // derives the counter position and the boundary from plain arithmetic.
    int run_cycles;
    int ticks;
    int act_a[N_CH], sh_a[N_CH], act_b[N_CH], sh_b[N_CH];

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int model_cnt(input int t);
`ifdef PWM_MULTI_CENTER_EN
        int pos = t % (2 * PERIOD);
        return (pos < PERIOD) ? pos : (2 * PERIOD - 1 - pos);
`else
        return t % PERIOD;
`endif
    endfunction

    function automatic bit model_last_tick(input int t);
`ifdef PWM_MULTI_CENTER_EN
        return (t % (2 * PERIOD)) == 2 * PERIOD - 1;
`else
        return (t % PERIOD) == PERIOD - 1;
`endif
    endfunction

    function automatic bit next_edge_is_boundary();
        return run && ((run_cycles % PRESC) == PRESC - 1) && model_last_tick(ticks);
    endfunction

    task automatic model_reset();
        run_cycles = 0;
        ticks = 0;
        for (int i = 0; i < N_CH; i++) begin
            act_a[i] = PERIOD / 2; sh_a[i] = PERIOD / 2;
            act_b[i] = PERIOD / 2; sh_b[i] = PERIOD / 2;
        end
    endtask

    // Advance one clock with the current inputs and compare all outputs.
    task automatic step();
        bit tick, bnd, wr, cl_a, cl_b;
        int c;
        logic [N_CH-1:0] ea, eb;
        tick = run && ((run_cycles % PRESC) == PRESC - 1);
        c    = model_cnt(ticks);
        bnd  = tick && model_last_tick(ticks);
        wr   = duty_valid && (int'(duty_ch) < N_CH);
        for (int i = 0; i < N_CH; i++) begin
            ea[i] = oe[i] && (c < act_a[i]);
            eb[i] = oe[i] && (c < act_b[i]);
        end
        cl_a = wr && (clampi(int'(duty), 0, PERIOD) != int'(duty));
        cl_b = wr && (clampi(int'(duty), 1, 9) != int'(duty));
        @(posedge clk);
        #1;
        check("out_a", out_a, ea);
        check("out_b", out_b, eb);
        check("out_en_a", out_en_a, oe);
        check("out_en_b", out_en_b, oe);
        check("period_tick_a", ptick_a, bnd);
        check("period_tick_b", ptick_b, bnd);
        check("clamped_a", clamped_a, cl_a);
        check("clamped_b", clamped_b, cl_b);
        if (bnd) begin
            for (int i = 0; i < N_CH; i++) begin
                act_a[i] = sh_a[i];
                act_b[i] = sh_b[i];
            end
        end
        if (wr) begin
            sh_a[duty_ch] = clampi(int'(duty), 0, PERIOD);
            sh_b[duty_ch] = clampi(int'(duty), 1, 9);
            $display("write ch=%0d duty=%0d t=%0t", duty_ch, duty, $time);
        end
        if (run) run_cycles++;
        if (tick) ticks++;
    endtask

    task automatic write_step(input int ch, input int d);
        duty_valid = 1'b1;
        duty_ch    = ch[1:0];
        duty       = d[RES_W-1:0];
        step();
        duty_valid = 1'b0;
    endtask

    // Reset asserted between clock edges. All outputs must drop immediately.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_a", out_a, 0);
        check("rst_out_b", out_b, 0);
        check("rst_out_en_a", out_en_a, 0);
        check("rst_flags_a", {ptick_a, clamped_a}, 0);
        check("rst_flags_b", {ptick_b, clamped_b}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        $display("reset released t=%0t", $time);
    endtask

    // Bounded wait for a period_tick on instance A; returns cycles consumed.
    task automatic wait_ptick(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!ptick_a && cycles < 200);
        if (!ptick_a) check("ptick_timeout", 0, 1);
    endtask

    typedef struct {
        int ch;
        int duty;
        bit cl_a;
        bit cl_b;
    } wr_vec_t;

    wr_vec_t vecs[8];

    initial begin
        int cyc, high, per;
        vecs[0] = '{0,   0, 1'b0, 1'b1};
        vecs[1] = '{0, 200, 1'b1, 1'b1};
        vecs[2] = '{0,   4, 1'b0, 1'b0};
        vecs[3] = '{0,  10, 1'b0, 1'b1};
        vecs[4] = '{0,   9, 1'b0, 1'b0};
        vecs[5] = '{1,   1, 1'b0, 1'b0};
        vecs[6] = '{1,  11, 1'b1, 1'b1};
        vecs[7] = '{3,  10, 1'b0, 1'b1};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", {out_a, out_b}, 0);
        check("reset_out_en", {out_en_a, out_en_b}, 0);
        check("reset_flags", {ptick_a, ptick_b, clamped_a, clamped_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;
        oe = 4'hF;

        // Default duty: period length and high time per period.
        wait_ptick(cyc);
        per = 0;
        high = 0;
        do begin
            step();
            per++;
            if (out_a[0]) high++;
        end while (!ptick_a && per < 200);
        check("period_clk", per, EXP_PER_CLK);
        check("high_clk", high, EXP_HIGH_CLK);

        // Mid-period write to ch2: model checks deferred application.
        repeat (5) step();
        write_step(2, 3);
        repeat (3 * EXP_PER_CLK) step();

        // Clamp table.
        for (int v = 0; v < 8; v++) begin
            write_step(vecs[v].ch, vecs[v].duty);
            check($sformatf("tbl%0d_clamped_a", v), clamped_a, vecs[v].cl_a);
            check($sformatf("tbl%0d_clamped_b", v), clamped_b, vecs[v].cl_b);
            step();
        end

        // Duty 0 and duty PERIOD: constant levels across three periods.
        write_step(1, 0);
        write_step(3, PERIOD);
        wait_ptick(cyc);
        for (int i = 0; i < 3 * EXP_PER_CLK; i++) begin
            step();
            check("const0_ch1", out_a[1], 1'b0);
            check("const1_ch3", out_a[3], 1'b1);
        end

        // run=0 hold, oe drop, then resume.
        repeat (3) step();
        run = 1'b0;
        repeat (8) step();
        oe[0] = 1'b0;
        repeat (4) step();
        oe[0] = 1'b1;
        run = 1'b1;
        repeat (10) step();

        // Write landing exactly on a boundary applies one period later.
        for (int i = 0; i < 200 && !next_edge_is_boundary(); i++) step();
        write_step(2, 7);
        repeat (2 * EXP_PER_CLK + 4) step();

        // Asynchronous reset mid-period.
        repeat (7) step();
        do_reset();
        repeat (EXP_PER_CLK + 3) step();

        // Randomized traffic.
        for (int n = 0; n < 2500; n++) begin
            run = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) oe = 4'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                duty_valid = 1'b1;
                duty_ch = 2'($urandom);
                duty = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, PERIOD));
            end
            step();
            duty_valid = 1'b0;
            if ($urandom_range(0, 599) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
